// File: rtl/ninety_nine_seq.sv
// Ninety-Nine round sequencer: phase FSM, BCD score and countdown, prompt pick, best score.
// Every output is a register updated on hz100; reset is synchronous and active-low.
module ninety_nine_seq #(
  parameter logic [7:0]  START_SCORE = 8'h99,
  parameter int unsigned GAP_TICKS   = 20
) (
  input  logic       hz100,
  input  logic       reset,
  input  logic       key_pulse,
  input  logic [2:0] key_code,
  input  logic [2:0] rand_bits,
  output logic [1:0] phase,
  output logic [2:0] prompt,
  output logic [7:0] score,
  output logic [7:0] time_now,
  output logic [7:0] best,
  output logic       hit,
  output logic       miss,
  output logic       win
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_PROMPT = 2'b01,
    S_GAP    = 2'b10,
    S_OVER   = 2'b11
  } state_t;

  state_t     r_state, w_state;
  logic [2:0] r_prompt, w_prompt;
  logic [2:0] r_last, w_last;
  logic [7:0] r_score, w_score;
  logic [7:0] r_time, w_time;
  logic [7:0] r_best, w_best;
  logic [7:0] r_gap, w_gap;
  logic       r_hit, w_hit;
  logic       r_miss, w_miss;
  logic       r_win, w_win;
  logic [7:0] w_score_dec;

  // Two-digit BCD decrement that saturates at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)
      return 8'h00;
    else if (v[3:0] == 4'h0)
      return {v[7:4] - 4'd1, 4'h9};
    else
      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Valid, non-repeating candidates pass straight through; otherwise step past prev.
  function automatic logic [2:0] pick(input logic [2:0] cand, input logic [2:0] prev);
    if (cand >= 3'd1 && cand <= 3'd6 && cand != prev)
      return cand;
    else if (prev >= 3'd6 || prev == 3'd0)
      return 3'd1;
    else
      return prev + 3'd1;
  endfunction

  assign w_score_dec = bcd_dec(r_score);

  always_comb begin
    w_state  = r_state;
    w_prompt = r_prompt;
    w_last   = r_last;
    w_score  = r_score;
    w_time   = r_time;
    w_best   = r_best;
    w_gap    = r_gap;
    w_hit    = 1'b0;
    w_miss   = 1'b0;
    w_win    = r_win;
    case (r_state)
      S_IDLE: begin
        if (key_pulse && key_code == 3'd1) begin
          w_state  = S_PROMPT;
          w_time   = r_score;
          w_prompt = pick(rand_bits, 3'd0);
          w_last   = w_prompt;
        end
      end
      S_PROMPT: begin
        // Timeout outranks any key arriving on the same cycle.
        if (r_time == 8'h00) begin
          w_state  = S_OVER;
          w_miss   = 1'b1;
          w_prompt = '0;
          if (r_score < r_best) w_best = r_score;
        end else if (key_pulse && key_code == r_prompt) begin
          w_hit    = 1'b1;
          w_score  = w_score_dec;
          w_prompt = '0;
          if (w_score_dec == 8'h00) begin
            w_state = S_OVER;
            w_win   = 1'b1;
            if (w_score_dec < r_best) w_best = w_score_dec;
          end else begin
            w_state = S_GAP;
            w_gap   = 8'(GAP_TICKS - 1);
          end
        end else if (key_pulse) begin
          w_state  = S_OVER;
          w_miss   = 1'b1;
          w_prompt = '0;
          if (r_score < r_best) w_best = r_score;
        end else begin
          w_time = bcd_dec(r_time);
        end
      end
      S_GAP: begin
        if (r_gap == 8'h00) begin
          w_state  = S_PROMPT;
          w_time   = r_score;
          w_prompt = pick(rand_bits, r_last);
          w_last   = w_prompt;
        end else begin
          w_gap = r_gap - 8'd1;
        end
      end
      S_OVER: begin
        if (key_pulse && key_code == 3'd1) begin
          w_state = S_IDLE;
          w_score = START_SCORE;
          w_time  = START_SCORE;
          w_win   = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge hz100) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_prompt <= '0;
      r_last   <= '0;
      r_score  <= START_SCORE;
      r_time   <= START_SCORE;
      r_best   <= 8'h99;
      r_gap    <= '0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_win    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_prompt <= w_prompt;
      r_last   <= w_last;
      r_score  <= w_score;
      r_time   <= w_time;
      r_best   <= w_best;
      r_gap    <= w_gap;
      r_hit    <= w_hit;
      r_miss   <= w_miss;
      r_win    <= w_win;
    end
  end

  assign phase    = r_state;
  assign prompt   = r_prompt;
  assign score    = r_score;
  assign time_now = r_time;
  assign best     = r_best;
  assign hit      = r_hit;
  assign miss     = r_miss;
  assign win      = r_win;

endmodule

// File: tb/tb_ninety_nine_seq.sv
// Bench for ninety_nine_seq: a decimal-integer game model feeds a scoreboard queue,
// and each scenario task adds its own spot checks on the values the game must show.
module tb_ninety_nine_seq;

  localparam int GAP = 20;

  logic       clk = 1'b0;
  logic       rst_n, kp, k2p;
  logic [2:0] kc, rb, k2c, r2b;

  logic [1:0] ph, ph2;
  logic [2:0] pr, pr2;
  logic [7:0] sc, tm, bs, sc2, tm2, bs2;
  logic       h, m, w, h2, m2, w2;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] sb_e, sb_a;

  int m_ph, m_pr, m_last, m_sc, m_tm, m_bs, m_hit, m_miss, m_win, m_gap;

  always #5 clk = ~clk;

  ninety_nine_seq dut (
    .hz100(clk), .reset(rst_n), .key_pulse(kp), .key_code(kc), .rand_bits(rb),
    .phase(ph), .prompt(pr), .score(sc), .time_now(tm), .best(bs),
    .hit(h), .miss(m), .win(w)
  );

  ninety_nine_seq #(.START_SCORE(8'h02), .GAP_TICKS(3)) dut2 (
    .hz100(clk), .reset(rst_n), .key_pulse(k2p), .key_code(k2c), .rand_bits(r2b),
    .phase(ph2), .prompt(pr2), .score(sc2), .time_now(tm2), .best(bs2),
    .hit(h2), .miss(m2), .win(w2)
  );

  function automatic int to_bcd(input int d);
    return (d / 10) * 16 + (d % 10);
  endfunction

  function automatic int pick_m(input int c, input int p);
    if (c >= 1 && c <= 6 && c != p) return c;
    return (p % 6) + 1;
  endfunction

  function automatic logic [31:0] model_vec();
    return {2'(m_ph), 3'(m_pr), 8'(to_bcd(m_sc)), 8'(to_bcd(m_tm)), 8'(to_bcd(m_bs)),
            1'(m_hit), 1'(m_miss), 1'(m_win)};
  endfunction

  task automatic model_step(input logic r, input logic p, input int c, input int rn);
    m_hit  = 0;
    m_miss = 0;
    if (!r) begin
      m_ph = 0; m_pr = 0; m_last = 0; m_sc = 99; m_tm = 99; m_bs = 99; m_win = 0; m_gap = 0;
    end else begin
      case (m_ph)
        0: if (p && c == 1) begin
          m_ph = 1; m_tm = m_sc; m_pr = pick_m(rn, 0); m_last = m_pr;
        end
        1: begin
          if (m_tm == 0) begin
            m_ph = 3; m_miss = 1; m_pr = 0;
            if (m_sc < m_bs) m_bs = m_sc;
          end else if (p && c == m_pr) begin
            m_hit = 1; m_pr = 0;
            if (m_sc > 0) m_sc = m_sc - 1;
            if (m_sc == 0) begin
              m_ph = 3; m_win = 1;
              if (m_sc < m_bs) m_bs = m_sc;
            end else begin
              m_ph = 2; m_gap = GAP;
            end
          end else if (p) begin
            m_ph = 3; m_miss = 1; m_pr = 0;
            if (m_sc < m_bs) m_bs = m_sc;
          end else begin
            m_tm = m_tm - 1;
          end
        end
        2: begin
          m_gap = m_gap - 1;
          if (m_gap == 0) begin
            m_ph = 1; m_tm = m_sc; m_pr = pick_m(rn, m_last); m_last = m_pr;
          end
        end
        default: if (p && c == 1) begin
          m_ph = 0; m_sc = 99; m_tm = 99; m_win = 0;
        end
      endcase
    end
  endtask

  // Called at a negedge: drive one cycle, queue its expected outcome, return at next negedge.
  task automatic step(input logic r, input logic p, input logic [2:0] c, input logic [2:0] rn);
    rst_n = r; kp = p; kc = c; rb = rn;
    model_step(r, p, int'(c), int'(rn));
    exp_q.push_back(model_vec());
    @(negedge clk);
    k2p = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      sb_a = {ph, pr, sc, tm, bs, h, m, w};
      n_vec++;
      if (sb_a !== sb_e) begin
        n_err++;
        $display("FAIL scoreboard t=%0t act=%h exp=%h", $time, sb_a, sb_e);
      end
    end
  end

  task automatic test_reset();
    step(1'b0, 1'b0, 3'd0, 3'd0);
    step(1'b1, 1'b1, 3'd1, 3'd3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd0, 3'd3);
    step(1'b0, 1'b1, 3'd1, 3'd0);
    step(1'b0, 1'b0, 3'd0, 3'd0);
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if (ph !== 2'b00) begin n_err++; $display("FAIL rst_phase act=%h exp=00", ph); end
    n_vec++; if (sc !== 8'h99) begin n_err++; $display("FAIL rst_score act=%h exp=99", sc); end
    n_vec++; if (tm !== 8'h99) begin n_err++; $display("FAIL rst_time act=%h exp=99", tm); end
    n_vec++; if (bs !== 8'h99) begin n_err++; $display("FAIL rst_best act=%h exp=99", bs); end
    n_vec++; if ({pr, h, m, w} !== 6'd0) begin n_err++; $display("FAIL rst_flags act=%h exp=00", {pr, h, m, w}); end
    n_vec++; if ({sc2, tm2} !== 16'h0202) begin n_err++; $display("FAIL rst_dut2 act=%h exp=0202", {sc2, tm2}); end
  endtask

  task automatic test_hit();
    step(1'b1, 1'b1, 3'd1, 3'd3);
    n_vec++; if ({ph, pr, tm} !== {2'b01, 3'd3, 8'h99}) begin n_err++; $display("FAIL start act=%h exp=%h", {ph, pr, tm}, {2'b01, 3'd3, 8'h99}); end
    for (int i = 0; i < 49; i++) step(1'b1, 1'b0, 3'd0, 3'd3);
    n_vec++; if (tm !== 8'h50) begin n_err++; $display("FAIL countdown act=%h exp=50", tm); end
    step(1'b1, 1'b1, 3'd3, 3'd3);
    n_vec++; if ({h, sc, ph} !== {1'b1, 8'h98, 2'b10}) begin n_err++; $display("FAIL hit act=%h exp=%h", {h, sc, ph}, {1'b1, 8'h98, 2'b10}); end
    for (int i = 0; i < GAP - 1; i++) step(1'b1, 1'b1, 3'd3, 3'd3);
    n_vec++; if ({ph, pr, tm} !== {2'b10, 3'd0, 8'h50}) begin n_err++; $display("FAIL gap_hold act=%h exp=%h", {ph, pr, tm}, {2'b10, 3'd0, 8'h50}); end
    step(1'b1, 1'b0, 3'd0, 3'd3);
    n_vec++; if ({ph, pr, tm} !== {2'b01, 3'd4, 8'h98}) begin n_err++; $display("FAIL reprompt act=%h exp=%h", {ph, pr, tm}, {2'b01, 3'd4, 8'h98}); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 98; i++) step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if ({ph, tm} !== {2'b01, 8'h00}) begin n_err++; $display("FAIL at_zero act=%h exp=%h", {ph, tm}, {2'b01, 8'h00}); end
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if ({ph, m, bs} !== {2'b11, 1'b1, 8'h98}) begin n_err++; $display("FAIL timeout act=%h exp=%h", {ph, m, bs}, {2'b11, 1'b1, 8'h98}); end
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if ({m, sc, tm} !== {1'b0, 8'h98, 8'h00}) begin n_err++; $display("FAIL over_hold act=%h exp=%h", {m, sc, tm}, {1'b0, 8'h98, 8'h00}); end
    step(1'b1, 1'b1, 3'd1, 3'd0);
    n_vec++; if ({ph, sc, bs} !== {2'b00, 8'h99, 8'h98}) begin n_err++; $display("FAIL restart act=%h exp=%h", {ph, sc, bs}, {2'b00, 8'h99, 8'h98}); end
  endtask

  task automatic test_wrong();
    step(1'b1, 1'b1, 3'd2, 3'd2);
    n_vec++; if (ph !== 2'b00) begin n_err++; $display("FAIL idle_ignore act=%h exp=00", ph); end
    step(1'b1, 1'b1, 3'd1, 3'd2);
    n_vec++; if (pr !== 3'd2) begin n_err++; $display("FAIL prompt2 act=%h exp=2", pr); end
    step(1'b1, 1'b1, 3'd5, 3'd2);
    n_vec++; if ({ph, m, h, sc} !== {2'b11, 1'b1, 1'b0, 8'h99}) begin n_err++; $display("FAIL wrong_key act=%h exp=%h", {ph, m, h, sc}, {2'b11, 1'b1, 1'b0, 8'h99}); end
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if (m !== 1'b0) begin n_err++; $display("FAIL miss_width act=%h exp=0", m); end
    step(1'b1, 1'b1, 3'd1, 3'd0);
    step(1'b1, 1'b1, 3'd1, 3'd1);
    for (int i = 0; i < 99; i++) step(1'b1, 1'b0, 3'd0, 3'd1);
    step(1'b1, 1'b1, 3'd1, 3'd1);
    n_vec++; if ({ph, m, h, sc} !== {2'b11, 1'b1, 1'b0, 8'h99}) begin n_err++; $display("FAIL key_at_zero act=%h exp=%h", {ph, m, h, sc}, {2'b11, 1'b1, 1'b0, 8'h99}); end
    step(1'b1, 1'b1, 3'd1, 3'd0);
  endtask

  task automatic test_prompt_seq();
    int       expp;
    int       nxt;
    logic [2:0] rn;
    step(1'b1, 1'b1, 3'd1, 3'd7);
    expp = 1;
    n_vec++; if (pr !== 3'd1) begin n_err++; $display("FAIL seq_first act=%h exp=1", pr); end
    for (int k = 1; k <= 12; k++) begin
      rn = (k <= 6) ? 3'd7 : 3'(expp);
      step(1'b1, 1'b1, 3'(expp), rn);
      for (int i = 0; i < GAP; i++) step(1'b1, 1'b0, 3'd0, rn);
      nxt = (expp % 6) + 1;
      n_vec++; if (pr !== 3'(nxt) || pr === 3'(expp)) begin n_err++; $display("FAIL seq_%0d act=%h exp=%h", k, pr, 3'(nxt)); end
      expp = nxt;
    end
    step(1'b1, 1'b1, 3'd0, 3'd0);
    step(1'b1, 1'b1, 3'd1, 3'd0);
  endtask

  task automatic test_win();
    k2p = 1'b1; k2c = 3'd1; r2b = 3'd4;
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if ({ph2, pr2, sc2, tm2} !== {2'b01, 3'd4, 8'h02, 8'h02}) begin n_err++; $display("FAIL w_start act=%h exp=%h", {ph2, pr2, sc2, tm2}, {2'b01, 3'd4, 8'h02, 8'h02}); end
    k2p = 1'b1; k2c = 3'd4;
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if ({h2, sc2, ph2} !== {1'b1, 8'h01, 2'b10}) begin n_err++; $display("FAIL w_hit1 act=%h exp=%h", {h2, sc2, ph2}, {1'b1, 8'h01, 2'b10}); end
    step(1'b1, 1'b0, 3'd0, 3'd0);
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if (ph2 !== 2'b10) begin n_err++; $display("FAIL w_gap act=%h exp=10", ph2); end
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if ({ph2, pr2, tm2} !== {2'b01, 3'd5, 8'h01}) begin n_err++; $display("FAIL w_reprompt act=%h exp=%h", {ph2, pr2, tm2}, {2'b01, 3'd5, 8'h01}); end
    k2p = 1'b1; k2c = 3'd5;
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if ({sc2, ph2, w2, bs2, h2} !== {8'h00, 2'b11, 1'b1, 8'h00, 1'b1}) begin n_err++; $display("FAIL w_win act=%h exp=%h", {sc2, ph2, w2, bs2, h2}, {8'h00, 2'b11, 1'b1, 8'h00, 1'b1}); end
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if ({w2, h2} !== 2'b10) begin n_err++; $display("FAIL w_level act=%h exp=2", {w2, h2}); end
    k2p = 1'b1; k2c = 3'd1;
    step(1'b1, 1'b0, 3'd0, 3'd0);
    n_vec++; if ({ph2, sc2, w2, bs2} !== {2'b00, 8'h02, 1'b0, 8'h00}) begin n_err++; $display("FAIL w_restart act=%h exp=%h", {ph2, sc2, w2, bs2}, {2'b00, 8'h02, 1'b0, 8'h00}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; kp = 1'b0; kc = '0; rb = '0;
    k2p = 1'b0; k2c = '0; r2b = '0;
    test_reset();
    test_hit();
    test_timeout();
    test_wrong();
    test_prompt_seq();
    test_win();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
